// File: rtl/gate_driver_pkg.sv
// Shared state encoding, retry counter type and timing helpers for the gate-driver fault supervisor.
// Latency: none (declarations only).
// Backpressure: none.
package gate_driver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DECIDE,
    REQ,
    WAIT_DONE,
    SETTLE,
    LOCKOUT
  } supervisor_state_t;

  typedef logic [3:0] retry_cnt_t;

  // Terminal count for a microsecond interval; a counter starting at 0 spans the full interval.
  function automatic int us_to_ticks(input int clk_freq_hz, input int time_us);
    return (clk_freq_hz / 1_000_000) * time_us - 1;
  endfunction

  // Combined retry count, pinned at 15 so the 4-bit report never wraps.
  function automatic retry_cnt_t retry_sum_sat(input retry_cnt_t a, input retry_cnt_t b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[4] ? 4'hF : sum[3:0];
  endfunction

endpackage

// File: rtl/gate_driver_fault_filter.sv
// Synchronizes the open-drain nFAULT line and confirms a fault once it has stayed low for the filter time.
// Latency: fault_active rises 2 sync cycles plus filter_ticks+1 low samples after the fall; drops 3 cycles after release.
// Backpressure: none; the filter runs every cycle regardless of supervisor state.
module gate_driver_fault_filter
  import gate_driver_pkg::*;
#(
  parameter int clk_freq_hz     = 54_000_000,
  parameter int fault_filter_us = 2
) (
  input  logic i_sys_clk,
  input  logic i_reset,
  input  logic i_fault_n,
  output logic o_fault_active
);

  localparam int                FILTER_TICKS = us_to_ticks(clk_freq_hz, fault_filter_us);
  localparam int                FILTER_W     = $clog2(FILTER_TICKS) + 1;
  localparam logic [FILTER_W-1:0] FILTER_MAX = FILTER_W'(FILTER_TICKS);

  logic                r_sync1;
  logic                r_sync2;
  logic [FILTER_W-1:0] r_cnt;
  logic                r_fault_active;

  // Two-flop synchronizer; idles high so reset never looks like a fault.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_fault_n;
      r_sync2 <= r_sync1;
    end
  end

  // Count continuous low samples; any high sample restarts the count and drops the confirmation.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset || r_sync2) begin
      r_cnt          <= '0;
      r_fault_active <= 1'b0;
    end else begin
      if (r_cnt != FILTER_MAX) begin
        r_cnt <= r_cnt + FILTER_W'(1);
      end
      if (r_cnt == FILTER_MAX) begin
        r_fault_active <= 1'b1;
      end
    end
  end

  assign o_fault_active = r_fault_active;

endmodule

// File: rtl/gate_driver_fault_supervisor.sv
// Decides fast/slow gate-driver resets from the filtered nFAULT line, escalating to a latched lockout.
// Latency: reset_start pulses 2 cycles after fault confirmation; lockout 1 cycle after the last retry is refused.
// Backpressure: waits on the reset stage's reset_done edge (bounded by a timeout); optional log outputs under GATE_DRIVER_FAULT_LOG_EN.
module gate_driver_fault_supervisor
  import gate_driver_pkg::*;
#(
  parameter int clk_freq_hz      = 54_000_000,
  parameter int fault_filter_us  = 2,
  parameter int settle_us        = 100,
  parameter int done_timeout_us  = 50,
  parameter int healthy_clear_us = 10_000,
  parameter int max_fast_retries = 2,
  parameter int max_slow_retries = 1
) (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic        i_fault_n,
  input  logic        i_enable_req,
  input  logic        i_clear_lockout,
  input  logic        i_reset_done,
  output logic        o_driver_enable,
  output logic        o_reset_start,
  output logic        o_slow_reset,
  output logic        o_fault_active,
  output logic        o_locked_out,
  output logic [3:0]  o_retry_count
`ifdef GATE_DRIVER_FAULT_LOG_EN
  ,
  output logic [15:0] o_fault_total,
  output logic        o_last_slow
`endif
);

  localparam int SETTLE_TICKS  = us_to_ticks(clk_freq_hz, settle_us);
  localparam int DONE_TICKS    = us_to_ticks(clk_freq_hz, done_timeout_us);
  localparam int HEALTHY_TICKS = us_to_ticks(clk_freq_hz, healthy_clear_us);
  localparam int SETTLE_W      = $clog2(SETTLE_TICKS) + 1;
  localparam int DONE_W        = $clog2(DONE_TICKS) + 1;
  localparam int HEALTHY_W     = $clog2(HEALTHY_TICKS) + 1;

  localparam logic [SETTLE_W-1:0]  SETTLE_MAX  = SETTLE_W'(SETTLE_TICKS);
  localparam logic [DONE_W-1:0]    DONE_MAX    = DONE_W'(DONE_TICKS);
  localparam logic [HEALTHY_W-1:0] HEALTHY_MAX = HEALTHY_W'(HEALTHY_TICKS);
  localparam retry_cnt_t           MAX_FAST    = retry_cnt_t'(max_fast_retries);
  localparam retry_cnt_t           MAX_SLOW    = retry_cnt_t'(max_slow_retries);

  supervisor_state_t      r_state;
  logic                   r_driver_enable;
  logic                   r_reset_start;
  logic                   r_slow_reset;
  logic                   r_locked_out;
  retry_cnt_t             r_fast_cnt;
  retry_cnt_t             r_slow_cnt;
  logic [HEALTHY_W-1:0]   r_healthy_cnt;
  logic [DONE_W-1:0]      r_done_cnt;
  logic [SETTLE_W-1:0]    r_settle_cnt;
  logic                   r_done_q;

  logic                   w_fault_active;
  logic                   w_done_rise;

  gate_driver_fault_filter #(
    .clk_freq_hz     (clk_freq_hz),
    .fault_filter_us (fault_filter_us)
  ) u_fault_filter (
    .i_sys_clk      (i_sys_clk),
    .i_reset        (i_reset),
    .i_fault_n      (i_fault_n),
    .o_fault_active (w_fault_active)
  );

  // Delayed copy of reset_done so only a fresh rising edge counts as completion.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= i_reset_done;
    end
  end

  assign w_done_rise = i_reset_done & ~r_done_q;

  // Supervisor FSM: outputs are registered alongside each state transition.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_driver_enable <= 1'b0;
      r_reset_start   <= 1'b0;
      r_slow_reset    <= 1'b0;
      r_locked_out    <= 1'b0;
      r_fast_cnt      <= '0;
      r_slow_cnt      <= '0;
      r_healthy_cnt   <= '0;
      r_done_cnt      <= '0;
      r_settle_cnt    <= '0;
    end else begin
      r_reset_start <= 1'b0;
      case (r_state)
        IDLE: begin
          r_fast_cnt    <= '0;
          r_slow_cnt    <= '0;
          r_healthy_cnt <= '0;
          r_done_cnt    <= '0;
          r_settle_cnt  <= '0;
          r_slow_reset  <= 1'b0;
          if (i_enable_req) begin
            r_state         <= RUN;
            r_driver_enable <= 1'b1;
          end
        end

        RUN: begin
          // Host shutdown wins over a simultaneous fault.
          if (!i_enable_req) begin
            r_state         <= IDLE;
            r_driver_enable <= 1'b0;
          end else if (w_fault_active) begin
            r_state <= DECIDE;
          end else if (r_healthy_cnt == HEALTHY_MAX) begin
            r_fast_cnt <= '0;
            r_slow_cnt <= '0;
          end else begin
            r_healthy_cnt <= r_healthy_cnt + HEALTHY_W'(1);
          end
        end

        DECIDE: begin
          if (r_fast_cnt < MAX_FAST) begin
            r_fast_cnt    <= r_fast_cnt + 4'd1;
            r_slow_reset  <= 1'b0;
            r_reset_start <= 1'b1;
            r_state       <= REQ;
          end else if (r_slow_cnt < MAX_SLOW) begin
            r_slow_cnt    <= r_slow_cnt + 4'd1;
            r_slow_reset  <= 1'b1;
            r_reset_start <= 1'b1;
            r_state       <= REQ;
          end else begin
            r_state         <= LOCKOUT;
            r_driver_enable <= 1'b0;
            r_locked_out    <= 1'b1;
            r_slow_reset    <= 1'b0;
          end
        end

        REQ: begin
          r_state    <= WAIT_DONE;
          r_done_cnt <= '0;
        end

        WAIT_DONE: begin
          // A reset in flight always runs to completion; enable_req is only consulted at the end.
          if (w_done_rise) begin
            r_slow_reset <= 1'b0;
            if (!i_enable_req) begin
              r_state         <= IDLE;
              r_driver_enable <= 1'b0;
            end else begin
              r_state      <= SETTLE;
              r_settle_cnt <= '0;
            end
          end else if (r_done_cnt == DONE_MAX) begin
            r_state         <= LOCKOUT;
            r_driver_enable <= 1'b0;
            r_locked_out    <= 1'b1;
            r_slow_reset    <= 1'b0;
          end else begin
            r_done_cnt <= r_done_cnt + DONE_W'(1);
          end
        end

        SETTLE: begin
          // Faults are blanked here; the filter keeps integrating so a persistent fault is ready at the end.
          if (!i_enable_req) begin
            r_state         <= IDLE;
            r_driver_enable <= 1'b0;
          end else if (r_settle_cnt == SETTLE_MAX) begin
            if (w_fault_active) begin
              r_state <= DECIDE;
            end else begin
              r_state       <= RUN;
              r_healthy_cnt <= '0;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
          end
        end

        LOCKOUT: begin
          if (i_clear_lockout && !i_enable_req) begin
            r_state      <= IDLE;
            r_locked_out <= 1'b0;
            r_fast_cnt   <= '0;
            r_slow_cnt   <= '0;
          end
        end

        default: begin
          r_state         <= IDLE;
          r_driver_enable <= 1'b0;
          r_slow_reset    <= 1'b0;
          r_locked_out    <= 1'b0;
        end
      endcase
    end
  end

  assign o_driver_enable = r_driver_enable;
  assign o_reset_start   = r_reset_start;
  assign o_slow_reset    = r_slow_reset;
  assign o_fault_active  = w_fault_active;
  assign o_locked_out    = r_locked_out;
  assign o_retry_count   = retry_sum_sat(r_fast_cnt, r_slow_cnt);

`ifdef GATE_DRIVER_FAULT_LOG_EN
  logic [15:0] r_fault_total;
  logic        r_last_slow;

  // Count confirmed faults (one per DECIDE cycle) and remember the type of the latest reset request.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_fault_total <= '0;
      r_last_slow   <= 1'b0;
    end else begin
      if ((r_state == DECIDE) && (r_fault_total != 16'hFFFF)) begin
        r_fault_total <= r_fault_total + 16'd1;
      end
      if (r_state == REQ) begin
        r_last_slow <= r_slow_reset;
      end
    end
  end

  assign o_fault_total = r_fault_total;
  assign o_last_slow   = r_last_slow;
`endif

endmodule

// File: tb/tb_gate_driver_fault_supervisor.sv
// Bench for gate_driver_fault_supervisor: filter vectors, randomized filter model, and escalation/lockout sequences.
// The healthy-clear time is shortened to 200 us so the recovery path fits in a short run; all else is default.
// Clock period is arbitrary; expected cycle counts derive from 54 ticks per microsecond.
module tb_gate_driver_fault_supervisor;

  localparam int TPU          = 54;                 // ticks per microsecond at 54 MHz
  localparam int FILTER_LOW   = TPU * 2;            // low samples needed to confirm a fault
  localparam int SYNC_DELAY   = 2;
  localparam int DONE_CYC     = TPU * 50;           // WAIT_DONE entry to lockout
  localparam int HEALTHY_US   = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        fault_n;
  logic        enable_req;
  logic        clear_lockout;
  logic        reset_done;
  logic        driver_enable;
  logic        reset_start;
  logic        slow_reset;
  logic        fault_active;
  logic        locked_out;
  logic [3:0]  retry_count;
`ifdef GATE_DRIVER_FAULT_LOG_EN
  logic [15:0] fault_total;
  logic        last_slow;
`endif

  int checks   = 0;
  int failures = 0;
  bit resp_en  = 1'b0;
  int man_cnt  = 0;
  bit rs_q[$];

  always #5 clk = ~clk;

  gate_driver_fault_supervisor #(
    .healthy_clear_us (HEALTHY_US)
  ) dut (
    .i_sys_clk       (clk),
    .i_reset         (rst),
    .i_fault_n       (fault_n),
    .i_enable_req    (enable_req),
    .i_clear_lockout (clear_lockout),
    .i_reset_done    (reset_done),
    .o_driver_enable (driver_enable),
    .o_reset_start   (reset_start),
    .o_slow_reset    (slow_reset),
    .o_fault_active  (fault_active),
    .o_locked_out    (locked_out),
    .o_retry_count   (retry_count)
`ifdef GATE_DRIVER_FAULT_LOG_EN
    ,
    .o_fault_total   (fault_total),
    .o_last_slow     (last_slow)
`endif
  );

  typedef struct {
    int low_cycles;
    int exp_active_cycles;
    int exp_first;
  } filt_vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    enable_req    = 1'b0;
    fault_n       = 1'b1;
    clear_lockout = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic pulse_fault(input int len);
    fault_n = 1'b0;
    tick(len);
    fault_n = 1'b1;
  endtask

  task automatic wait_rs(input int budget, output bit found, output bit slow);
    found = 1'b0;
    slow  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (reset_start) begin
        found = 1'b1;
        slow  = slow_reset;
        break;
      end
    end
  endtask

  function automatic int rs_at(input int idx);
    if (idx < rs_q.size()) return int'(rs_q[idx]);
    return -1;
  endfunction

  // Records slow_reset on every reset_start cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_start === 1'b1) rs_q.push_back(slow_reset);
    end
  end

  // Reset-stage model: reset_done rises 10 cycles after a request, or on a manual request.
  initial begin
    int man_seen;
    man_seen   = 0;
    reset_done = 1'b0;
    forever begin
      @(negedge clk);
      if ((resp_en && reset_start === 1'b1) || (man_cnt != man_seen)) begin
        man_seen = man_cnt;
        repeat (10) @(negedge clk);
        reset_done = 1'b1;
        repeat (3) @(negedge clk);
        reset_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    filt_vec_t vecs[6];
    int  first, act_cnt, rs_cnt, run, n, bad;
    int  runq[$];
    bit  found, slow, seen;

    vecs[0] = '{100, 0, -1};
    vecs[1] = '{107, 0, -1};
    vecs[2] = '{108, 1, FILTER_LOW + SYNC_DELAY};
    vecs[3] = '{109, 2, FILTER_LOW + SYNC_DELAY};
    vecs[4] = '{120, 13, FILTER_LOW + SYNC_DELAY};
    vecs[5] = '{3, 0, -1};

    rst = 1'b1; fault_n = 1'b1; enable_req = 1'b0; clear_lockout = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_driver_enable", driver_enable, 0);
    check("rst_reset_start", reset_start, 0);
    check("rst_slow_reset", slow_reset, 0);
    check("rst_fault_active", fault_active, 0);
    check("rst_locked_out", locked_out, 0);
    check("rst_retry_count", retry_count, 0);
    tick(3);

    // Filter vectors with the supervisor idle.
    foreach (vecs[v]) begin
      fault_n = 1'b0;
      first = -1; act_cnt = 0; rs_cnt = 0;
      for (int j = 1; j <= vecs[v].low_cycles + 20; j++) begin
        @(negedge clk);
        if (fault_active) begin
          act_cnt++;
          if (first < 0) first = j;
        end
        if (reset_start || driver_enable) rs_cnt++;
        if (j == vecs[v].low_cycles) fault_n = 1'b1;
      end
      check($sformatf("filt%0d_active_cycles", vecs[v].low_cycles), act_cnt, vecs[v].exp_active_cycles);
      check($sformatf("filt%0d_first_assert", vecs[v].low_cycles), first, vecs[v].exp_first);
      check($sformatf("filt%0d_idle_quiet", vecs[v].low_cycles), rs_cnt, 0);
      tick(10);
    end

    // Randomized filter: confirmed iff the last FILTER_LOW samples, seen through the synchronizer, were all low.
    runq = {0, 0};
    run  = 0;
    for (int seg = 0; seg < 30; seg++) begin
      int len;
      if (seg % 2 == 0) begin
        fault_n = 1'b0;
        len = $urandom_range(125, 95);
      end else begin
        fault_n = 1'b1;
        len = $urandom_range(15, 1);
      end
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        run = fault_n ? 0 : run + 1;
        runq.push_back(run);
        check("rand_fault_active", fault_active, (runq[runq.size()-1-SYNC_DELAY] >= FILTER_LOW) ? 1 : 0);
      end
    end
    fault_n = 1'b1;
    tick(5);

    // Recovery: short glitch ignored, two fast resets, healthy run clears counters, next fault is fast again.
    do_reset();
    rs_q.delete();
    resp_en = 1'b1;
    enable_req = 1'b1;
    tick(4);
    check("rec_run_driver_enable", driver_enable, 1);
    pulse_fault(100);
    tick(150);
    check("rec_short_no_reset", rs_q.size(), 0);
    pulse_fault(120);
    tick(5600);
    check("rec_first_reset_count", rs_q.size(), 1);
    check("rec_first_is_fast", rs_at(0), 0);
    check("rec_first_retry", retry_count, 1);
    check("rec_back_to_run", driver_enable, 1);
    pulse_fault(120);
    tick(5600);
    check("rec_second_is_fast", rs_at(1), 0);
    check("rec_second_retry", retry_count, 2);
    tick(10000);
    check("rec_not_cleared_early", retry_count, 2);
    tick(1000);
    check("rec_healthy_cleared", retry_count, 0);
    pulse_fault(120);
    tick(50);
    check("rec_third_count", rs_q.size(), 3);
    check("rec_third_is_fast", rs_at(2), 0);
    check("rec_third_retry", retry_count, 1);

    // Escalation: persistent fault gives fast, fast, slow, then lockout.
    do_reset();
    rs_q.delete();
    resp_en = 1'b1;
    enable_req = 1'b1;
    tick(3);
    fault_n = 1'b0;
    found = 1'b0; bad = 0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (reset_start && !driver_enable) bad++;
      if (locked_out) begin
        found = 1'b1;
        break;
      end
    end
    check("esc_lockout_reached", found, 1);
    check("esc_reset_count", rs_q.size(), 3);
    check("esc_reset0_fast", rs_at(0), 0);
    check("esc_reset1_fast", rs_at(1), 0);
    check("esc_reset2_slow", rs_at(2), 1);
    check("esc_enable_during_reset", bad, 0);
    check("esc_driver_enable", driver_enable, 0);
    check("esc_retry_count", retry_count, 3);
    check("esc_slow_reset_low", slow_reset, 0);
`ifdef GATE_DRIVER_FAULT_LOG_EN
    check("esc_fault_total", fault_total, 4);
    check("esc_last_slow", last_slow, 1);
`endif
    fault_n = 1'b1;
    tick(20);

    // Timeout: reset_done never arrives.
    do_reset();
    resp_en = 1'b0;
    enable_req = 1'b1;
    tick(3);
    fault_n = 1'b0;
    wait_rs(300, found, slow);
    fault_n = 1'b1;
    check("to_reset_start_seen", found, 1);
    check("to_reset_is_fast", slow, 0);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      n++;
      if (locked_out) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_locked", seen, 1);
    check("to_latency", n, DONE_CYC + 1);
    check("to_driver_enable", driver_enable, 0);

    // Lockout clear is honoured only with enable_req low.
    clear_lockout = 1'b1;
    @(negedge clk);
    clear_lockout = 1'b0;
    tick(2);
    check("clr_ignored_with_enable", locked_out, 1);
    enable_req = 1'b0;
    tick(2);
    check("clr_still_locked", locked_out, 1);
    clear_lockout = 1'b1;
    @(negedge clk);
    clear_lockout = 1'b0;
    check("clr_unlocked", locked_out, 0);
    check("clr_retry_cleared", retry_count, 0);
    enable_req = 1'b1;
    tick(2);
    check("clr_rerun", driver_enable, 1);

    // Synchronous reset while waiting for reset_done.
    do_reset();
    resp_en = 1'b0;
    enable_req = 1'b1;
    tick(3);
    fault_n = 1'b0;
    wait_rs(300, found, slow);
    check("mid_reset_start_seen", found, 1);
    tick(5);
    rst = 1'b1;
    enable_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fault_n = 1'b1;
    check("mid_driver_enable", driver_enable, 0);
    check("mid_reset_start", reset_start, 0);
    check("mid_slow_reset", slow_reset, 0);
    check("mid_fault_active", fault_active, 0);
    check("mid_locked_out", locked_out, 0);
    check("mid_retry_count", retry_count, 0);
    tick(3);
    man_cnt++;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reset_start || driver_enable || locked_out) bad++;
    end
    check("mid_late_done_ignored", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
